// File: rtl/seg_pkg.sv
// Shared types, constants and the hex font for the seven-segment scan driver.
package seg_pkg;

    // Segment vector, ordered {g,f,e,d,c,b,a}, active-low
    typedef logic [6:0] seg_t;

    // All segments off
    localparam seg_t SEG_BLANK = 7'h7F;

    // Hex font for a common-anode display (a 0 lights the segment)
    function automatic seg_t hex2seg(input logic [3:0] nib);
        seg_t s;
        case (nib)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Value-load and display-pin bundle for seg_scan_driver.
// master: the result logic that loads values and reads the display pins back.
// slave:  the scan driver itself.
interface seg_scan_driver_if #(
    parameter int NUM_DIGITS = 8
);
    import seg_pkg::*;

    logic [4*NUM_DIGITS-1:0] data_i;
    logic [NUM_DIGITS-1:0]   dp_i;
    logic [NUM_DIGITS-1:0]   blank_i;
    logic                    load_i;
    logic                    pending_o;
    seg_t                    seg_o;
    logic                    dp_o;
    logic [NUM_DIGITS-1:0]   an_o;

    modport master (
        output data_i, dp_i, blank_i, load_i,
        input  pending_o, seg_o, dp_o, an_o
    );

    modport slave (
        input  data_i, dp_i, blank_i, load_i,
        output pending_o, seg_o, dp_o, an_o
    );

endinterface

// File: rtl/seg_hex_decode.sv
// Combinational hex-nibble to active-low segment decoder.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       seg
);

    assign seg = hex2seg(nibble);

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment driver for a common-anode display.
// Optional build macro: SEG_LEADING_ZERO_BLANK_EN (suppress leading zeros).
//
// Load handshake: load_i is a single-cycle strobe that is always accepted
// (there is no ready). Outside a frame end it captures data_i/dp_i/blank_i
// into the pending buffer and pending_o goes high the next cycle; pending_o
// stays high until the next frame end commits that buffer to the display.
// A load landing on the frame-end cycle goes straight to the display.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int CLK_DIV    = 100000
) (
    input logic              clk,
    input logic              rst,
    seg_scan_driver_if.slave bus
);

    localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PC_W  = $clog2(CLK_DIV);

    localparam logic [PC_W-1:0]       LAST_PC  = PC_W'(CLK_DIV - 1);
    localparam logic [DIG_W-1:0]      LAST_IDX = DIG_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] DIGIT0   = NUM_DIGITS'(1);

    logic [PC_W-1:0]         pcnt;
    logic [DIG_W-1:0]        idx;
    logic                    afterTick;
    logic                    tick;
    logic                    frameEnd;

    logic [4*NUM_DIGITS-1:0] pendData;
    logic [NUM_DIGITS-1:0]   pendDp;
    logic [NUM_DIGITS-1:0]   pendBlank;
    logic                    pending;

    logic [4*NUM_DIGITS-1:0] dispData;
    logic [NUM_DIGITS-1:0]   dispDp;
    logic [NUM_DIGITS-1:0]   dispBlank;

    logic [NUM_DIGITS-1:0]   effBlank;
    logic [3:0]              curNib;
    seg_t                    curSeg;

    seg_t                    segReg;
    logic                    dpReg;
    logic [NUM_DIGITS-1:0]   anReg;

    assign tick     = (pcnt == LAST_PC);
    assign frameEnd = tick && (idx == LAST_IDX);

    // Prescaler and digit index; afterTick marks the anti-ghost dead cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt      <= '0;
            idx       <= '0;
            afterTick <= 1'b0;
        end else begin
            afterTick <= tick;
            if (tick) begin
                pcnt <= '0;
                idx  <= (idx == LAST_IDX) ? '0 : idx + DIG_W'(1);
            end else begin
                pcnt <= pcnt + PC_W'(1);
            end
        end
    end

    // Double buffer: loads park in pend*, commit to disp* only at frame end
    always_ff @(posedge clk) begin
        if (rst) begin
            pendData  <= '0;
            pendDp    <= '0;
            pendBlank <= '0;
            pending   <= 1'b0;
            dispData  <= '0;
            dispDp    <= '0;
            dispBlank <= '1;
        end else if (frameEnd) begin
            // A load on the boundary itself is the newest value and wins
            if (bus.load_i) begin
                dispData  <= bus.data_i;
                dispDp    <= bus.dp_i;
                dispBlank <= bus.blank_i;
            end else if (pending) begin
                dispData  <= pendData;
                dispDp    <= pendDp;
                dispBlank <= pendBlank;
            end
            pending <= 1'b0;
        end else if (bus.load_i) begin
            pendData  <= bus.data_i;
            pendDp    <= bus.dp_i;
            pendBlank <= bus.blank_i;
            pending   <= 1'b1;
        end
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic zeroFromHere;

    // A digit is dark when it and every digit above it hold zero, unless its
    // decimal point is lit; digit 0 is never suppressed
    always_comb begin
        effBlank     = dispBlank;
        zeroFromHere = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zeroFromHere = zeroFromHere && (dispData[4*k +: 4] == 4'h0);
            if (zeroFromHere && !dispDp[k]) begin
                effBlank[k] = 1'b1;
            end
        end
    end
`else
    assign effBlank = dispBlank;
`endif

    assign curNib = dispData[{idx, 2'b00} +: 4];

    seg_hex_decode hexDecode (
        .nibble (curNib),
        .seg    (curSeg)
    );

    // Pin registers: one cycle behind idx/disp; anodes off for the dead cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            segReg <= SEG_BLANK;
            dpReg  <= 1'b1;
            anReg  <= '1;
        end else begin
            anReg  <= afterTick ? '1 : ~(DIGIT0 << idx);
            segReg <= effBlank[idx] ? SEG_BLANK : curSeg;
            dpReg  <= effBlank[idx] | ~dispDp[idx];
        end
    end

    assign bus.seg_o     = segReg;
    assign bus.dp_o      = dpReg;
    assign bus.an_o      = anReg;
    assign bus.pending_o = pending;

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed seven-segment display driver for a common-anode multi-digit display. It holds one 4-bit hex nibble per digit plus per-digit decimal point and blank mask, and scans the digits at a programmable refresh rate. It drives active-low segment and anode lines. New values are double-buffered and committed only at a frame boundary, so the display never tears. It sits between the arithmetic/result logic and the board's display pins, replacing purely combinational single-value decoders.

## Interface
- NUM_DIGITS, 8, number of digits scanned (1..16); DIG_W = max(1, $clog2(NUM_DIGITS))
- CLK_DIV, 100000, clock cycles each digit stays lit (>= 2)
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- data_i  in  4*NUM_DIGITS  hex nibble per digit; digit k = data_i[4k+3:4k]
- dp_i  in  NUM_DIGITS  decimal point on, per digit (active-high)
- blank_i  in  NUM_DIGITS  force digit dark, per digit (active-high)
- load_i  in  1  capture data_i/dp_i/blank_i this cycle
- pending_o  out  1  captured values not yet committed to display
- seg_o  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp_o  out  1  decimal point, active-low
- an_o  out  NUM_DIGITS  anode enables, active-low, one-hot-low

## Operation
- Prescaler: pcnt counts 0..CLK_DIV-1 and wraps. tick = (pcnt == CLK_DIV-1).
- Digit index: idx advances on tick and wraps from NUM_DIGITS-1 to 0. frame_end = tick && idx == NUM_DIGITS-1.
- Buffers: pending register (pend_*) and display register (disp_*).
  - A load_i in any cycle other than frame_end writes pend_* and sets pending_o. A second load before commit overwrites pend_*; last load wins.
  - On frame_end with pending_o=1: disp_* <= pend_* and pending_o clears.
  - load_i on the frame_end cycle writes data_i directly into disp_* and leaves pending_o at 0; it supersedes any older pend_*.
- Output for the current idx:
  - an_o = ~(1 << idx).
  - seg_o = hex font of disp nibble, with 7'h7F if the blank bit is set.
  - dp_o = ~dp bit, forced to 1 if blanked.
- Anti-ghost dead cycle: on the cycle after each tick, an_o = all ones. seg_o already shows the new digit.
- Hex font (active-low, g..a): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.

## Timing
- All outputs are registered, with 1-cycle latency from idx/disp state to pins.
- Reset values:
  - seg_o=7'h7F, dp_o=1, an_o=all ones, pending_o=0.
  - pcnt=0, idx=0, disp_*=0 with blank all set (dark until first commit), pend_*=0.
- First clock after rst deasserts: an_o=~1 (digit 0 lit, dark segments).
- Each digit is lit for CLK_DIV-1 cycles plus 1 dead cycle. Frame period = NUM_DIGITS*CLK_DIV cycles.
- Load-to-visible latency is at most one frame + 1 cycle. pending_o rises the cycle after load_i and falls the cycle after frame_end.
- rst mid-frame overrides everything, including a simultaneous load_i.
- NUM_DIGITS=1: idx is constant 0 and every tick is frame_end.

## Configuration
- SEG_LEADING_ZERO_BLANK_EN defined:
  - Digits above the most significant nonzero nibble are treated as blanked, unless their dp bit is set.
  - Digit 0 is never suppressed, so all-zero data shows a single "0".
  - Suppression is evaluated on disp_*, not pend_*.
- Undefined: all digits show their nibble unless blank_i masked them.

## Structure
- seg_pkg holds:
  - SEG_BLANK = 7'h7F.
  - Hex font function hex2seg(logic [3:0]) -> logic [6:0].
  - Typedef seg_t = logic [6:0].
- Sub-module seg_hex_decode: a combinational wrapper of hex2seg. The top instantiates it once, on the muxed nibble.
- The top contains the prescaler, idx, both buffers, the leading-zero logic and the output registers.

## Test plan
Bench parameters: NUM_DIGITS=4, CLK_DIV=4.
- Reset: hold rst 3 cycles. Expect seg_o=7F, an_o=F, dp_o=1. One cycle after release, an_o=E and seg_o=7F.
- Load 16'h3A10 with dp_i=0, blank_i=0 mid-frame. Expect pending_o=1 until frame_end. Next frame shows an_o=E/seg 40, D/79, B/08, 7/30, and each digit's first lit cycle is preceded by an_o=F.
- Two loads before commit: 16'h1111 then 16'h2222. Committed frame shows only 24 on all digits.
- load_i exactly on the frame_end cycle with 16'h8888: pending_o stays 0 and digit 0 shows seg 00 on the next lit cycle.
- blank_i=4'b0100 with dp_i=4'b0100, data 16'hFFFF: digit 2 shows seg 7F and dp_o=1; the others show 0E with dp_o=1.
- With SEG_LEADING_ZERO_BLANK_EN and data 16'h0000: digits 3..1 show 7F and digit 0 shows 40. With data 16'h0050: digits 3,2 are dark, digit 1 shows 12, digit 0 shows 40.
